// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: fetch/data arbiter for one single-ported memory         |
// | Data-first priority with fetch starvation guard.  Rev 1.0                 |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_size,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] BUSY_IF    = 2'd1;
  localparam logic [1:0] BUSY_D     = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  logic [1:0]        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_size_q, mem_size_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic              gnt_if, gnt_d;

  // Grants are combinational from the requests; forced low while in reset
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (d_req && (starve_q < STARVE_LIM)) gnt_d  = 1'b1;
      else if (if_req)                      gnt_if = 1'b1;
      else if (d_req)                       gnt_d  = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;

    if (!if_req || gnt_if)                        starve_d = 4'd0;
    else if (gnt_d && (starve_q < STARVE_LIM))    starve_d = starve_q + 4'd1;

    if (gnt_if) begin
      state_d     = BUSY_IF;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_size_d  = SIZE_WORD;
    end else if (gnt_d) begin
      state_d     = BUSY_D;
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_size_d  = d_size;
    end

    if (mem_ack) begin
      if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        if (state_q == BUSY_IF) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end else begin
          d_rvalid_d = 1'b1;
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= 3'd0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign if_gnt    = gnt_if;
  assign d_gnt     = gnt_d;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. Rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_size = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, err;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] exp_drdata = '0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: every completion pulse is matched against the scoreboard queue
  initial begin
    forever begin
      @(negedge clk);
      if (if_rvalid) begin
        if (exp_if_q.size() == 0) check("if_rvalid_unexpected", 32'd1, 32'd0);
        else check("if_rdata_scoreboard", if_rdata, exp_if_q.pop_front());
      end
      if (d_rvalid) begin
        if (exp_d_q.size() == 0) check("d_rvalid_unexpected", 32'd1, 32'd0);
        else check("d_rdata_scoreboard", d_rdata, exp_d_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] pattern;
    logic       exp_is_d;
    pattern = 8'b1110_1110;

    // Reset state
    step();
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_rdata", if_rdata | d_rdata, 32'd0);
    rst = 1'b0;
    step();

    // Single fetch, zero-wait memory
    if_req = 1'b1; if_addr = 8'h04; #1;
    check("fetch_if_gnt", {31'd0, if_gnt}, 32'd1);
    check("fetch_d_gnt", {31'd0, d_gnt}, 32'd0);
    exp_if_q.push_back(32'h00500093);
    step();
    check("fetch_mem_req", {31'd0, mem_req}, 32'd1);
    check("fetch_mem_addr", {24'd0, mem_addr}, 32'h04);
    check("fetch_mem_we", {31'd0, mem_we}, 32'd0);
    check("fetch_mem_size", {29'd0, mem_size}, 32'd2);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00500093;
    step();
    mem_ack = 1'b0;
    check("fetch_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("fetch_if_rdata", if_rdata, 32'h00500093);
    check("fetch_err", {31'd0, err}, 32'd0);
    check("fetch_busy_after", {31'd0, busy}, 32'd0);

    // Data write, 3-cycle memory latency
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF; d_size = 3'b010; #1;
    check("write_d_gnt", {31'd0, d_gnt}, 32'd1);
    exp_d_q.push_back(exp_drdata);
    step();
    d_req = 1'b0;
    check("write_mem_req_c1", {31'd0, mem_req}, 32'd1);
    check("write_mem_we", {31'd0, mem_we}, 32'd1);
    check("write_mem_addr", {24'd0, mem_addr}, 32'h10);
    check("write_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("write_mem_size", {29'd0, mem_size}, 32'd2);
    step();
    check("write_mem_req_c2", {31'd0, mem_req}, 32'd1);
    check("write_busy_c2", {31'd0, busy}, 32'd1);
    step();
    check("write_mem_req_c3", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    step();
    mem_ack = 1'b0;
    check("write_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("write_d_rdata_kept", d_rdata, exp_drdata);
    check("write_mem_req_c4", {31'd0, mem_req}, 32'd0);

    // Contention: both requesters held, zero-wait memory
    d_we = 1'b0; d_addr = 8'h40; if_addr = 8'h08;
    for (int i = 0; i < 8; i++) begin
      if_req = 1'b1; d_req = 1'b1; mem_ack = 1'b0; #1;
      exp_is_d = pattern[7-i];
      check($sformatf("contend_d_gnt_%0d", i), {31'd0, d_gnt}, {31'd0, exp_is_d});
      check($sformatf("contend_if_gnt_%0d", i), {31'd0, if_gnt}, {31'd0, ~exp_is_d});
      if (exp_is_d) exp_d_q.push_back(32'hD0000000 + i);
      else          exp_if_q.push_back(32'hF0000000 + i);
      step();
      mem_ack = 1'b1;
      mem_rdata = exp_is_d ? 32'hD0000000 + i : 32'hF0000000 + i;
      if (exp_is_d) exp_drdata = 32'hD0000000 + i;
      step();
    end
    mem_ack = 1'b0; if_req = 1'b0; d_req = 1'b0;
    step();

    // Reset during BUSY_D
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30; #1;
    check("abort_d_gnt", {31'd0, d_gnt}, 32'd1);
    step();
    d_req = 1'b0;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1; #1;
    check("abort_mem_req_async", {31'd0, mem_req}, 32'd0);
    check("abort_busy_async", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    exp_drdata = 32'd0;
    step();
    check("abort_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("abort_err_clear", {31'd0, err}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_ack = 1'b0;
    check("late_ack_err", {31'd0, err}, 32'd1);
    check("late_ack_d_rdata", d_rdata, 32'd0);

    // Spurious ack in IDLE after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("spur_err_before", {31'd0, err}, 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("spur_err_set", {31'd0, err}, 32'd1);
    check("spur_busy", {31'd0, busy}, 32'd0);
    step(); step();
    check("spur_err_sticky", {31'd0, err}, 32'd1);
    check("spur_mem_req", {31'd0, mem_req}, 32'd0);

    // Back-to-back zero-wait reads
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; #1;
    check("b2b_gnt0", {31'd0, d_gnt}, 32'd1);
    exp_d_q.push_back(32'h11112222);
    step();
    d_addr = 8'h24;
    check("b2b_mem_addr0", {24'd0, mem_addr}, 32'h20);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    step();
    mem_ack = 1'b0; #1;
    check("b2b_gnt2", {31'd0, d_gnt}, 32'd1);
    check("b2b_rvalid2", {31'd0, d_rvalid}, 32'd1);
    check("b2b_rdata2", d_rdata, 32'h11112222);
    exp_d_q.push_back(32'h33334444);
    step();
    d_req = 1'b0;
    check("b2b_mem_addr1", {24'd0, mem_addr}, 32'h24);
    mem_ack = 1'b1; mem_rdata = 32'h33334444;
    step();
    mem_ack = 1'b0;
    check("b2b_rvalid4", {31'd0, d_rvalid}, 32'd1);
    check("b2b_rdata4", d_rdata, 32'h33334444);
    step(); step();

    check("if_queue_drained", exp_if_q.size(), 32'd0);
    check("d_queue_drained", exp_d_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the instruction-fetch stage and the data-memory stage of the five-stage pipeline. It uses a fixed data-first priority with a starvation guard for fetch. Each transaction is a request/grant/complete handshake, and the block holds exactly one transaction outstanding. The pipeline uses `busy` and the per-port grants to generate its stall signals.

## Interface
Parameters:
- `ADDR_W`, default 8: address width. Matches the 8-bit PC.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 3: maximum consecutive data grants while a fetch is pending. Legal range is 1..15.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `if_req` in 1: fetch request. Held high, with `if_addr` stable, until `if_gnt`.
- `if_addr` in `ADDR_W`: fetch address.
- `if_gnt` out 1: one-cycle pulse; the fetch request is accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out `DATA_W`: fetched word. Registered; holds its value until the next fetch completion.
- `d_req` in 1: data request. Same hold rule as `if_req`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in `ADDR_W`: data address.
- `d_wdata` in `DATA_W`: write data.
- `d_size` in 3: datasize select. Forwarded unchanged to the memory.
- `d_gnt` out 1: one-cycle accept pulse.
- `d_rvalid` out 1: one-cycle completion pulse. Issued for reads and writes.
- `d_rdata` out `DATA_W`: read word. Updated only on read completion.
- `mem_req` out 1: memory request. Held high until `mem_ack`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_size` out 3: memory datasize.
- `mem_ack` in 1: one-cycle pulse; the transaction is done and `mem_rdata` is valid.
- `mem_rdata` in `DATA_W`: memory read data.
- `busy` out 1: high while a transaction is outstanding (state ≠ IDLE).
- `err` out 1: sticky protocol-error flag.

## Operation
- State machine states: IDLE, BUSY_IF, BUSY_D.
- In IDLE, grant selection is combinational from the `if_req`/`d_req` inputs:
  - If `d_req` is set and the starvation count is below `STARVE_MAX`, grant data.
  - Otherwise, if `if_req` is set, grant fetch.
  - Otherwise, if `d_req` is set, grant data.
  - At most one grant is asserted per cycle.
- On a grant:
  - Register the address, write enable, write data and size into the `mem_*` registers.
  - Move to BUSY_IF or BUSY_D.
  - Fetch grants always drive `mem_we` = 0 and `mem_size` = 3'b010 (word).
- Starvation counter (4-bit):
  - Increments on a data grant while `if_req` = 1.
  - Clears on a fetch grant, or in any cycle where `if_req` = 0.
  - Saturates at `STARVE_MAX`.
- In BUSY_x, `mem_req` = 1 and the `mem_*` registers are frozen. No grants are issued.
- On `mem_ack` in BUSY_x:
  - Go to IDLE.
  - On the next edge, pulse the owner's `rvalid`.
  - Load `if_rdata` (fetch) or `d_rdata` (data read) from `mem_rdata`. A data write pulses `d_rvalid` and leaves `d_rdata` unchanged.
- `mem_ack` while in IDLE: ignore it and set `err` = 1. `err` clears only on reset.
- Simultaneous `if_req` and `d_req` with the counter at `STARVE_MAX`: fetch wins, and the counter clears.
- A request deasserted before its grant is a requester protocol violation. It is not detected; the arbiter simply does not grant it.

## Timing
- Reset values: state IDLE, all outputs 0, starvation counter 0, `err` 0.
- Reset mid-transaction:
  - Return to IDLE immediately (asynchronous).
  - `mem_req` drops immediately.
  - No `rvalid` is issued for the aborted transaction.
  - A late `mem_ack` after reset counts as IDLE-ack and sets `err`.
- Cycle timeline for a transaction:
  - Cycle 0: the request is sampled in IDLE and `gnt` is high.
  - Cycle 1: `mem_req` is high.
  - Cycle k ≥ 1: `mem_ack` is high.
  - Cycle k+1: `rvalid` and `rdata` are valid, and the state is IDLE. A new grant is possible in this same cycle.
- With a zero-wait memory (ack in cycle 1), latency is 2 cycles from `gnt` to `rvalid`. Throughput is 1 transaction per 2 cycles.
- `busy` is registered: high from cycle 1 through cycle k.
- `mem_*` outputs are registered; there is no combinational path from `mem_ack` to `mem_req`.

## Test plan
- Single fetch:
  - Stimulus: `if_addr` = 8'h04; `mem_ack` at cycle 1 with `mem_rdata` = 32'h00500093.
  - Required: `if_gnt` at cycle 0, `mem_req`/`mem_addr` = 8'h04 at cycle 1, `if_rvalid` at cycle 2 with `if_rdata` = 32'h00500093, `err` = 0.
- Data write with 3-cycle memory latency:
  - Stimulus: `d_we` = 1, `d_addr` = 8'h10, `d_wdata` = 32'hDEADBEEF, `d_size` = 3'b010.
  - Required: `mem_req` high during cycles 1–3, `d_rvalid` at cycle 4, `d_rdata` unchanged.
- Contention and starvation, `STARVE_MAX` = 3:
  - Stimulus: `if_req` and `d_req` held high continuously.
  - Required: grant order D, D, D, IF, D, D, D, IF; never 4 consecutive data grants.
- Reset mid-transaction:
  - Stimulus: assert `rst` during BUSY_D, before `mem_ack`.
  - Required: `mem_req` = 0 and `busy` = 0 immediately; no `d_rvalid`. A following `mem_ack` sets `err` = 1.
- Spurious ack:
  - Stimulus: `mem_ack` pulsed while IDLE with no requests.
  - Required: `err` = 1 and stays 1; no `rvalid` pulses; state remains IDLE.
- Back-to-back zero-wait reads:
  - Stimulus: `d_req` held high with addresses 8'h20, 8'h24.
  - Required: grants at cycles 0 and 2; `d_rvalid` at cycles 2 and 4 with the matching data.
